// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream (PRGA) stage.
package rc4_pkg;

  localparam int S_SIZE      = 256;
  localparam int IDX_W       = $clog2(S_SIZE);
  localparam int MSG_LEN_DEF = 32;

  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_I,
    ST_WT_I,
    ST_RD_J,
    ST_WT_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_WT_F,
    ST_WR_D,
    ST_DONE
  } rc4_state_e;

endpackage

// File: rtl/rc4_ascii_check.sv
// Combinational plaintext filter: accepts lowercase letters and space only.
module rc4_ascii_check
  import rc4_pkg::*;
(
  input  logic [7:0] data_i,
  output logic       ok_o
);

  assign ok_o = ((data_i >= ASCII_LO) && (data_i <= ASCII_HI)) || (data_i == ASCII_SPACE);

endmodule

// File: rtl/rc4_prga.sv
// RC4 PRGA: walks the scheduled S RAM, XORs keystream with the encrypted ROM
// into the decrypted RAM. RC4_PRGA_ASCII_CHECK_EN enables the plaintext filter.
module rc4_prga
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       done,
  output logic [7:0] s_addr,
  output logic [7:0] s_wdata,
  output logic       s_wren,
  input  logic [7:0] s_rdata,
  output logic [7:0] enc_addr,
  input  logic [7:0] enc_rdata,
  output logic [7:0] dec_addr,
  output logic [7:0] dec_wdata,
  output logic       dec_wren,
  output logic       fail
);

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(MSG_LEN - 1);

  rc4_state_e       state_q;
  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic [7:0]       si_q, sj_q;
  logic             hold_q;
  logic [7:0]       s_addr_q, s_wdata_q, enc_addr_q, dec_addr_q, dec_wdata_q;
  logic             s_wren_q, dec_wren_q, done_q;
  logic [7:0]       plain_d;
  logic [IDX_W-1:0] j_d;

  assign plain_d = s_rdata ^ enc_rdata;
  assign j_d     = j_q + s_rdata;

`ifdef RC4_PRGA_ASCII_CHECK_EN
  logic plain_ok;
  logic bad_q;
  logic fail_q;

  rc4_ascii_check u_ascii_check (
    .data_i (plain_d),
    .ok_o   (plain_ok)
  );

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      hold_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wren_q    <= 1'b0;
      enc_addr_q  <= '0;
      dec_addr_q  <= '0;
      dec_wdata_q <= '0;
      dec_wren_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef RC4_PRGA_ASCII_CHECK_EN
      bad_q       <= 1'b0;
      fail_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            i_q      <= IDX_W'(1);
            j_q      <= '0;
            k_q      <= '0;
            s_addr_q <= 8'd1;
            done_q   <= 1'b0;
`ifdef RC4_PRGA_ASCII_CHECK_EN
            fail_q   <= 1'b0;
`endif
            state_q  <= ST_RD_I;
          end
        end
        ST_RD_I: state_q <= ST_WT_I;
        ST_WT_I: begin
          si_q     <= s_rdata;
          j_q      <= j_d;
          s_addr_q <= j_d;
          state_q  <= ST_RD_J;
        end
        ST_RD_J: state_q <= ST_WT_J;
        ST_WT_J: begin
          sj_q      <= s_rdata;
          s_addr_q  <= i_q;
          s_wdata_q <= s_rdata;
          s_wren_q  <= 1'b1;
          state_q   <= ST_WR_I;
        end
        ST_WR_I: begin
          s_addr_q  <= j_q;
          s_wdata_q <= si_q;
          state_q   <= ST_WR_J;
        end
        ST_WR_J: begin
          // Post-swap S[i]+S[j] equals the pre-swap sum, so the captured pair serves.
          s_wren_q   <= 1'b0;
          s_addr_q   <= si_q + sj_q;
          enc_addr_q <= k_q;
          state_q    <= ST_RD_F;
        end
        ST_RD_F: state_q <= ST_WT_F;
        ST_WT_F: begin
          dec_addr_q  <= k_q;
          dec_wdata_q <= plain_d;
          hold_q      <= 1'b0;
`ifdef RC4_PRGA_ASCII_CHECK_EN
          bad_q       <= ~plain_ok;
          dec_wren_q  <= plain_ok;
`else
          dec_wren_q  <= 1'b1;
`endif
          state_q     <= ST_WR_D;
        end
        ST_WR_D: begin
          // Second WR_D cycle is write-free and completes the ten-cycle byte slot.
          dec_wren_q <= 1'b0;
          hold_q     <= 1'b1;
          if (hold_q) begin
            if (k_q == LAST_K) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              k_q      <= k_q + IDX_W'(1);
              i_q      <= i_q + IDX_W'(1);
              s_addr_q <= i_q + IDX_W'(1);
              state_q  <= ST_RD_I;
            end
          end
`ifdef RC4_PRGA_ASCII_CHECK_EN
          if (bad_q) begin
            fail_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wren    = s_wren_q;
  assign enc_addr  = enc_addr_q;
  assign dec_addr  = dec_addr_q;
  assign dec_wdata = dec_wdata_q;
  assign dec_wren  = dec_wren_q;

endmodule
